// File: rtl/tail_lamp_decoder.sv
// rtl/tail_lamp_decoder.sv - passive tail-lamp bus decoder with turn-sweep tracking and error reporting
//
// Optional feature macro: TAIL_LAMP_DEC_COUNT_EN (builds the saturating event counters).
//
// Ports:
//   clk                      system clock, rising edge
//   reset                    asynchronous active-low reset
//   la, lb, lc               left lamp lines (a = innermost)
//   ra, rb, rc               right lamp lines (a = innermost)
//   err_clr                  synchronous clear of err_sticky
//   mode                     decoded mode: 0 OFF, 1 LEFT, 2 RIGHT, 3 FOG, 4 BRAKE_ALARM, 7 ILLEGAL
//   phase                    turn phase 1..3 while LEFT/RIGHT, else 0
//   left_done, right_done    one-cycle pulse after a complete legal sweep
//   err                      one-cycle pulse on a protocol violation
//   err_sticky               latched error flag
//   left_cnt, right_cnt, err_cnt  saturating event counters (0 when counters are not built)
module tail_lamp_decoder #(
    parameter int STEP_CYCLES = 1,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             la,
    input  logic             lb,
    input  logic             lc,
    input  logic             ra,
    input  logic             rb,
    input  logic             rc,
    input  logic             err_clr,
    output logic [2:0]       mode,
    output logic [1:0]       phase,
    output logic             left_done,
    output logic             right_done,
    output logic             err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] left_cnt,
    output logic [CNT_W-1:0] right_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [7:0] STEP = STEP_CYCLES[7:0];

    typedef enum logic [3:0] {
        C_OFF, C_L1, C_L2, C_L3, C_R1, C_R2, C_R3, C_FOG, C_BA, C_ILL
    } class_e;

    typedef enum logic [2:0] {
        S_IDLE, S_LTURN, S_RTURN, S_FOG, S_BA, S_RESYNC
    } state_e;

    class_e     cls;
    logic [1:0] lidx, ridx, turn_idx;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] tph_d;
    logic       viol, sweep_done;

    logic [2:0] mode_q, mode_d;
    logic [1:0] phase_q, phase_d;
    logic       left_done_q, left_done_d;
    logic       right_done_q, right_done_d;
    logic       err_q, err_d;
    logic       err_sticky_q, err_sticky_d;

    always_comb begin
        case ({la, lb, lc, ra, rb, rc})
            6'b000000: cls = C_OFF;
            6'b100000: cls = C_L1;
            6'b110000: cls = C_L2;
            6'b111000: cls = C_L3;
            6'b000100: cls = C_R1;
            6'b000110: cls = C_R2;
            6'b000111: cls = C_R3;
            6'b100100: cls = C_FOG;
            6'b111111: cls = C_BA;
            default:   cls = C_ILL;
        endcase
        lidx = (cls == C_L1) ? 2'd1 : (cls == C_L2) ? 2'd2 : (cls == C_L3) ? 2'd3 : 2'd0;
        ridx = (cls == C_R1) ? 2'd1 : (cls == C_R2) ? 2'd2 : (cls == C_R3) ? 2'd3 : 2'd0;
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            mode_q       <= '0;
            phase_q      <= '0;
            left_done_q  <= 1'b0;
            right_done_q <= 1'b0;
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mode_q       <= mode_d;
            phase_q      <= phase_d;
            left_done_q  <= left_done_d;
            right_done_q <= right_done_d;
            err_q        <= err_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    // Next-state logic. phase_q doubles as the current turn phase while in a turn state.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tph_d      = phase_q;
        viol       = 1'b0;
        sweep_done = 1'b0;
        turn_idx   = (state_q == S_RTURN) ? ridx : lidx;
        case (state_q)
            S_IDLE, S_FOG, S_BA: begin
                cnt_d = '0;
                tph_d = '0;
                case (cls)
                    C_OFF: state_d = S_IDLE;
                    C_FOG: state_d = S_FOG;
                    C_BA:  state_d = S_BA;
                    C_L1, C_R1: begin
                        // A sweep may only start from OFF.
                        if (state_q == S_IDLE) begin
                            state_d = (cls == C_L1) ? S_LTURN : S_RTURN;
                            tph_d   = 2'd1;
                            cnt_d   = 8'd1;
                        end else begin
                            viol = 1'b1;
                        end
                    end
                    default: viol = 1'b1;
                endcase
            end
            S_LTURN, S_RTURN: begin
                if (turn_idx == phase_q) begin
                    // Repeat of the current phase: legal only while shorter than STEP.
                    if (cnt_q < STEP) cnt_d = cnt_q + 8'd1;
                    else              viol  = 1'b1;
                end else if (turn_idx != 2'd0 && turn_idx == phase_q + 2'd1) begin
                    if (cnt_q == STEP) begin
                        tph_d = turn_idx;
                        cnt_d = 8'd1;
                    end else begin
                        viol = 1'b1;
                    end
                end else if (cls == C_OFF && phase_q == 2'd3 && cnt_q == STEP) begin
                    state_d    = S_IDLE;
                    cnt_d      = '0;
                    tph_d      = '0;
                    sweep_done = 1'b1;
                end else begin
                    viol = 1'b1;
                end
            end
            S_RESYNC: begin
                cnt_d = '0;
                tph_d = '0;
                if (cls == C_OFF) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                tph_d   = '0;
            end
        endcase
        if (viol) begin
            state_d = S_RESYNC;
            cnt_d   = '0;
            tph_d   = '0;
        end
    end

    // Output logic (registered, so it is driven from the next state)
    always_comb begin
        case (state_d)
            S_IDLE:  mode_d = 3'd0;
            S_LTURN: mode_d = 3'd1;
            S_RTURN: mode_d = 3'd2;
            S_FOG:   mode_d = 3'd3;
            S_BA:    mode_d = 3'd4;
            default: mode_d = 3'd7;
        endcase
        phase_d      = (state_d == S_LTURN || state_d == S_RTURN) ? tph_d : 2'd0;
        left_done_d  = sweep_done && (state_q == S_LTURN);
        right_done_d = sweep_done && (state_q == S_RTURN);
        err_d        = viol;
        // A new violation beats a simultaneous clear.
        err_sticky_d = viol ? 1'b1 : (err_clr ? 1'b0 : err_sticky_q);
    end

    assign mode       = mode_q;
    assign phase      = phase_q;
    assign left_done  = left_done_q;
    assign right_done = right_done_q;
    assign err        = err_q;
    assign err_sticky = err_sticky_q;

`ifdef TAIL_LAMP_DEC_COUNT_EN
    logic [CNT_W-1:0] left_cnt_q, left_cnt_d;
    logic [CNT_W-1:0] right_cnt_q, right_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        left_cnt_d  = (left_done_d  && left_cnt_q  != '1) ? left_cnt_q  + 1'b1 : left_cnt_q;
        right_cnt_d = (right_done_d && right_cnt_q != '1) ? right_cnt_q + 1'b1 : right_cnt_q;
        err_cnt_d   = (err_d        && err_cnt_q   != '1) ? err_cnt_q   + 1'b1 : err_cnt_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            left_cnt_q  <= '0;
            right_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            left_cnt_q  <= left_cnt_d;
            right_cnt_q <= right_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign left_cnt  = left_cnt_q;
    assign right_cnt = right_cnt_q;
    assign err_cnt   = err_cnt_q;
`else
    assign left_cnt  = '0;
    assign right_cnt = '0;
    assign err_cnt   = '0;
`endif

endmodule

// File: tb/tb_tail_lamp_decoder.sv
// tb/tb_tail_lamp_decoder.sv - directed self-checking bench for tail_lamp_decoder
module tb_tail_lamp_decoder;

`ifdef TAIL_LAMP_DEC_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam logic [5:0] P_OFF = 6'b000000;
    localparam logic [5:0] P_L1  = 6'b100000;
    localparam logic [5:0] P_L2  = 6'b110000;
    localparam logic [5:0] P_L3  = 6'b111000;
    localparam logic [5:0] P_R1  = 6'b000100;
    localparam logic [5:0] P_R2  = 6'b000110;
    localparam logic [5:0] P_R3  = 6'b000111;
    localparam logic [5:0] P_FOG = 6'b100100;
    localparam logic [5:0] P_BA  = 6'b111111;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic err_clr = 1'b0;
    logic [5:0] pat = 6'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // d1: STEP_CYCLES=1, CNT_W=8
    logic [2:0] m1; logic [1:0] p1; logic ld1, rd1, e1, es1;
    logic [7:0] lc1, rc1, ec1;
    // d3: STEP_CYCLES=3, CNT_W=8
    logic [2:0] m3; logic [1:0] p3; logic ld3, rd3, e3, es3;
    logic [7:0] lc3, rc3, ec3;
    // d2: STEP_CYCLES=1, CNT_W=2
    logic [2:0] m2; logic [1:0] p2; logic ld2, rd2, e2, es2;
    logic [1:0] lc2, rc2, ec2;

    tail_lamp_decoder #(.STEP_CYCLES(1), .CNT_W(8)) d1 (
        .clk(clk), .reset(reset), .la(pat[5]), .lb(pat[4]), .lc(pat[3]),
        .ra(pat[2]), .rb(pat[1]), .rc(pat[0]), .err_clr(err_clr),
        .mode(m1), .phase(p1), .left_done(ld1), .right_done(rd1), .err(e1),
        .err_sticky(es1), .left_cnt(lc1), .right_cnt(rc1), .err_cnt(ec1));

    tail_lamp_decoder #(.STEP_CYCLES(3), .CNT_W(8)) d3 (
        .clk(clk), .reset(reset), .la(pat[5]), .lb(pat[4]), .lc(pat[3]),
        .ra(pat[2]), .rb(pat[1]), .rc(pat[0]), .err_clr(err_clr),
        .mode(m3), .phase(p3), .left_done(ld3), .right_done(rd3), .err(e3),
        .err_sticky(es3), .left_cnt(lc3), .right_cnt(rc3), .err_cnt(ec3));

    tail_lamp_decoder #(.STEP_CYCLES(1), .CNT_W(2)) d2 (
        .clk(clk), .reset(reset), .la(pat[5]), .lb(pat[4]), .lc(pat[3]),
        .ra(pat[2]), .rb(pat[1]), .rc(pat[0]), .err_clr(err_clr),
        .mode(m2), .phase(p2), .left_done(ld2), .right_done(rd2), .err(e2),
        .err_sticky(es2), .left_cnt(lc2), .right_cnt(rc2), .err_cnt(ec2));

    // Drive a pattern at the falling edge; return 1 time unit after the sampling edge.
    task automatic apply(input logic [5:0] p);
        @(negedge clk);
        pat = p;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        pat = P_OFF;
        err_clr = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        if (m1 !== 3'd0) begin $display("FAIL reset_mode got %0d exp 0", m1); errors++; end checks++;
        if (p1 !== 2'd0) begin $display("FAIL reset_phase got %0d exp 0", p1); errors++; end checks++;
        if ({ld1, rd1, e1, es1} !== 4'b0) begin $display("FAIL reset_flags got %b exp 0000", {ld1, rd1, e1, es1}); errors++; end checks++;
        if ({lc1, rc1, ec1} !== 24'd0) begin $display("FAIL reset_cnts got %h exp 0", {lc1, rc1, ec1}); errors++; end checks++;
        reset = 1'b1;
    endtask

    task automatic test_left_sweep();
        do_reset();
        apply(P_OFF);
        if (m1 !== 3'd0) begin $display("FAIL ls_off_mode got %0d exp 0", m1); errors++; end checks++;
        apply(P_L1);
        if ({m1, p1} !== {3'd1, 2'd1}) begin $display("FAIL ls_l1 got %0d/%0d exp 1/1", m1, p1); errors++; end checks++;
        apply(P_L2);
        if ({m1, p1} !== {3'd1, 2'd2}) begin $display("FAIL ls_l2 got %0d/%0d exp 1/2", m1, p1); errors++; end checks++;
        apply(P_L3);
        if ({m1, p1, e1} !== {3'd1, 2'd3, 1'b0}) begin $display("FAIL ls_l3 got %0d/%0d/%0d exp 1/3/0", m1, p1, e1); errors++; end checks++;
        apply(P_OFF);
        if ({ld1, m1, e1} !== {1'b1, 3'd0, 1'b0}) begin $display("FAIL ls_done got %0d/%0d/%0d exp 1/0/0", ld1, m1, e1); errors++; end checks++;
        if (lc1 !== (CNT_EN ? 8'd1 : 8'd0)) begin $display("FAIL ls_cnt got %0d exp %0d", lc1, CNT_EN ? 1 : 0); errors++; end checks++;
        apply(P_OFF);
        if (ld1 !== 1'b0) begin $display("FAIL ls_done_pulse got %0d exp 0", ld1); errors++; end checks++;
    endtask

    task automatic test_right_step3();
        logic any_err;
        do_reset();
        apply(P_OFF);
        repeat (3) apply(P_R1);
        if ({m3, p3, e3} !== {3'd2, 2'd1, 1'b0}) begin $display("FAIL r3_r1 got %0d/%0d/%0d exp 2/1/0", m3, p3, e3); errors++; end checks++;
        repeat (2) apply(P_R2);
        apply(P_R3);
        if ({e3, m3, p3} !== {1'b1, 3'd7, 2'd0}) begin $display("FAIL r3_short got %0d/%0d/%0d exp 1/7/0", e3, m3, p3); errors++; end checks++;
        apply(P_R3);
        if ({e3, m3} !== {1'b0, 3'd7}) begin $display("FAIL r3_resync got %0d/%0d exp 0/7", e3, m3); errors++; end checks++;
        apply(P_OFF);
        if ({m3, rd3} !== {3'd0, 1'b0}) begin $display("FAIL r3_off got %0d/%0d exp 0/0", m3, rd3); errors++; end checks++;
        any_err = 1'b0;
        repeat (3) begin apply(P_R1); any_err |= e3; end
        repeat (3) begin apply(P_R2); any_err |= e3; end
        repeat (3) begin apply(P_R3); any_err |= e3; end
        if ({m3, p3} !== {3'd2, 2'd3}) begin $display("FAIL r3_r3 got %0d/%0d exp 2/3", m3, p3); errors++; end checks++;
        apply(P_OFF);
        if ({rd3, any_err | e3} !== 2'b10) begin $display("FAIL r3_done got %0d/%0d exp 1/0", rd3, any_err | e3); errors++; end checks++;
        if ({rc3, ec3} !== (CNT_EN ? {8'd1, 8'd1} : 16'd0)) begin $display("FAIL r3_cnts got %0d/%0d exp %0d/%0d", rc3, ec3, CNT_EN ? 1 : 0, CNT_EN ? 1 : 0); errors++; end checks++;
        // A phase held one cycle too long is also a violation.
        repeat (3) apply(P_R1);
        if (e3 !== 1'b0) begin $display("FAIL r3_long_ok got %0d exp 0", e3); errors++; end checks++;
        apply(P_R1);
        if ({e3, m3} !== {1'b1, 3'd7}) begin $display("FAIL r3_long got %0d/%0d exp 1/7", e3, m3); errors++; end checks++;
    endtask

    task automatic test_illegal();
        do_reset();
        apply(P_OFF);
        apply(6'b010000);
        if ({e1, es1, m1} !== {1'b1, 1'b1, 3'd7}) begin $display("FAIL ill_first got %0d/%0d/%0d exp 1/1/7", e1, es1, m1); errors++; end checks++;
        apply(P_OFF);
        if ({e1, es1, m1} !== {1'b0, 1'b1, 3'd0}) begin $display("FAIL ill_off got %0d/%0d/%0d exp 0/1/0", e1, es1, m1); errors++; end checks++;
        @(negedge clk);
        err_clr = 1'b1;
        pat = 6'b001001;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        if ({e1, es1} !== 2'b11) begin $display("FAIL ill_clr_race got %0d/%0d exp 1/1", e1, es1); errors++; end checks++;
        if (ec1 !== (CNT_EN ? 8'd2 : 8'd0)) begin $display("FAIL ill_errcnt got %0d exp %0d", ec1, CNT_EN ? 2 : 0); errors++; end checks++;
        apply(6'b010000);
        if ({e1, m1} !== {1'b0, 3'd7}) begin $display("FAIL ill_resync1 got %0d/%0d exp 0/7", e1, m1); errors++; end checks++;
        apply(6'b011011);
        if ({e1, m1} !== {1'b0, 3'd7}) begin $display("FAIL ill_resync2 got %0d/%0d exp 0/7", e1, m1); errors++; end checks++;
        @(negedge clk);
        err_clr = 1'b1;
        pat = P_OFF;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        if ({es1, m1} !== {1'b0, 3'd0}) begin $display("FAIL ill_clr got %0d/%0d exp 0/0", es1, m1); errors++; end checks++;
        if (ec1 !== (CNT_EN ? 8'd2 : 8'd0)) begin $display("FAIL ill_errcnt2 got %0d exp %0d", ec1, CNT_EN ? 2 : 0); errors++; end checks++;
    endtask

    task automatic test_fog_ba();
        logic [5:0] seq [5];
        logic [2:0] exp_m [5];
        seq = '{P_FOG, P_BA, P_FOG, P_OFF, P_BA};
        exp_m = '{3'd3, 3'd4, 3'd3, 3'd0, 3'd4};
        do_reset();
        apply(P_OFF);
        for (int i = 0; i < 5; i++) begin
            apply(seq[i]);
            if ({m1, e1, p1} !== {exp_m[i], 1'b0, 2'd0}) begin $display("FAIL fogba_%0d got %0d/%0d/%0d exp %0d/0/0", i, m1, e1, p1, exp_m[i]); errors++; end checks++;
        end
        apply(P_L1);
        if ({e1, m1} !== {1'b1, 3'd7}) begin $display("FAIL ba_to_l1 got %0d/%0d exp 1/7", e1, m1); errors++; end checks++;
    endtask

    task automatic test_reset_mid_sweep();
        do_reset();
        apply(P_OFF);
        apply(P_L1);
        apply(P_L2);
        if ({m1, p1} !== {3'd1, 2'd2}) begin $display("FAIL rm_l2 got %0d/%0d exp 1/2", m1, p1); errors++; end checks++;
        reset = 1'b0;
        #1;
        if ({m1, p1, ld1, e1, es1} !== 7'd0) begin $display("FAIL rm_async got %0d/%0d/%0d/%0d/%0d exp all 0", m1, p1, ld1, e1, es1); errors++; end checks++;
        pat = P_OFF;
        @(negedge clk);
        reset = 1'b1;
        apply(P_L3);
        if ({e1, m1} !== {1'b1, 3'd7}) begin $display("FAIL rm_l3 got %0d/%0d exp 1/7", e1, m1); errors++; end checks++;
        apply(P_OFF);
        if ({ld1, m1} !== {1'b0, 3'd0}) begin $display("FAIL rm_off got %0d/%0d exp 0/0", ld1, m1); errors++; end checks++;
    endtask

    task automatic test_saturate();
        do_reset();
        apply(P_OFF);
        for (int s = 1; s <= 5; s++) begin
            apply(P_L1);
            apply(P_L2);
            apply(P_L3);
            apply(P_OFF);
            if (ld2 !== 1'b1) begin $display("FAIL sat_done_%0d got %0d exp 1", s, ld2); errors++; end checks++;
            if (lc2 !== (CNT_EN ? 2'((s > 3) ? 3 : s) : 2'd0)) begin $display("FAIL sat_cnt_%0d got %0d exp %0d", s, lc2, CNT_EN ? ((s > 3) ? 3 : s) : 0); errors++; end checks++;
        end
        if (lc1 !== (CNT_EN ? 8'd5 : 8'd0)) begin $display("FAIL sat_wide got %0d exp %0d", lc1, CNT_EN ? 5 : 0); errors++; end checks++;
    endtask

    initial begin
        test_reset();
        test_left_sweep();
        test_right_step3();
        test_illegal();
        test_fog_ba();
        test_reset_mid_sweep();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
